// File: rtl/uart_tx_arbiter.sv
// Two-source 8N1 UART transmitter: a debug bridge and the SoC UART share one txd line.
// Define UART_TX_ARB_RR_EN for round-robin arbitration; otherwise the debug bridge has fixed priority.
module uart_tx_arbiter #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUDRATE = 1000000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       dbg_valid_i,
  input  logic [7:0] dbg_data_i,
  output logic       dbg_accept_o,
  input  logic       soc_valid_i,
  input  logic [7:0] soc_data_i,
  output logic       soc_accept_o,
  output logic       txd_o,
  output logic       busy_o,
  output logic       owner_o
);

  // DIV must be at least 4 for the counter width and bit timing to make sense.
  localparam int DIV = CLK_FREQ / BAUDRATE;
  localparam int CW  = $clog2(DIV);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // Handshake: a source holds valid and data stable until it sees its accept high
  // for one cycle; accept is only raised in IDLE and only to the granted source.
  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      data_q, data_d;
  logic            owner_q, owner_d;
  logic            txd_q, txd_d;
  logic            grant_dbg, grant_soc;
  logic            can_accept;
  logic            cnt_last;

`ifdef UART_TX_ARB_RR_EN
  // On a tie the source that did not send the last frame wins.
  assign grant_dbg = dbg_valid_i & (~soc_valid_i | ~owner_q);
`else
  assign grant_dbg = dbg_valid_i;
`endif
  assign grant_soc = soc_valid_i & ~grant_dbg;

  assign can_accept   = (state_q == IDLE) & ~rst_i;
  assign dbg_accept_o = can_accept & grant_dbg;
  assign soc_accept_o = can_accept & grant_soc;

  assign cnt_last = (cnt_q == CW'(DIV - 1));

  assign txd_o   = txd_q;
  assign busy_o  = (state_q != IDLE);
  assign owner_o = owner_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    data_d  = data_q;
    owner_d = owner_q;
    txd_d   = txd_q;
    case (state_q)
      IDLE: begin
        txd_d = 1'b1;
        if (dbg_accept_o || soc_accept_o) begin
          data_d  = dbg_accept_o ? dbg_data_i : soc_data_i;
          owner_d = dbg_accept_o;
          state_d = START;
          cnt_d   = '0;
          bit_d   = '0;
          txd_d   = 1'b0;
        end
      end
      START: begin
        if (cnt_last) begin
          state_d = DATA;
          cnt_d   = '0;
          bit_d   = '0;
          txd_d   = data_q[0];
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (cnt_last) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            bit_d   = '0;
            txd_d   = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            txd_d = data_q[bit_q + 3'd1];
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (cnt_last) begin
          state_d = IDLE;
          cnt_d   = '0;
          txd_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        txd_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      owner_q <= 1'b0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      owner_q <= owner_d;
      txd_q   <= txd_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter at default parameters (DIV = 50).
// Expectations follow UART_TX_ARB_RR_EN when the bench is compiled with it.
module tb_uart_tx_arbiter;

  localparam int DIV = 50;
  localparam int FRAME = 10 * DIV;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       dbg_valid_i = 1'b0;
  logic [7:0] dbg_data_i = 8'h00;
  logic       dbg_accept_o;
  logic       soc_valid_i = 1'b0;
  logic [7:0] soc_data_i = 8'h00;
  logic       soc_accept_o;
  logic       txd_o;
  logic       busy_o;
  logic       owner_o;

  int n_tests = 0;
  int n_fail  = 0;

  uart_tx_arbiter dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .dbg_valid_i  (dbg_valid_i),
    .dbg_data_i   (dbg_data_i),
    .dbg_accept_o (dbg_accept_o),
    .soc_valid_i  (soc_valid_i),
    .soc_data_i   (soc_data_i),
    .soc_accept_o (soc_accept_o),
    .txd_o        (txd_o),
    .busy_o       (busy_o),
    .owner_o      (owner_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic rst;
    logic dv;
    logic sv;
    logic exp_da;
    logic exp_sa;
  } vec_t;

  vec_t vecs[7];

  task automatic wait_edge();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic check_accept(input string name, input logic exp_d, input logic exp_s);
    check1(name, {30'd0, dbg_accept_o, soc_accept_o}, {30'd0, exp_d, exp_s});
  endtask

  // Follows one frame cycle by cycle from its first cycle; returns at frame cycle n.
  task automatic check_frame(input logic [7:0] b, input logic own, input int n,
                             input int soc_at, input int dbg_at);
    logic [9:0] fr;
    logic       bad, acc_bad;
    logic       a_txd, a_busy;
    int         k;
    fr = {1'b1, b, 1'b0};
    bad = 1'b0;
    acc_bad = 1'b0;
    a_txd = 1'b0;
    a_busy = 1'b0;
    check1("owner in frame", {31'd0, owner_o}, {31'd0, own});
    for (int i = 0; i < n; i++) begin
      k = i / DIV;
      if (!bad && (txd_o !== fr[k] || busy_o !== 1'b1)) begin
        bad = 1'b1;
        a_txd = txd_o;
        a_busy = busy_o;
      end
      if (dbg_accept_o !== 1'b0 || soc_accept_o !== 1'b0) acc_bad = 1'b1;
      if (i == soc_at) begin
        soc_valid_i = 1'b1;
        soc_data_i  = 8'hB2;
      end
      if (i == dbg_at) begin
        dbg_valid_i = 1'b1;
        dbg_data_i  = 8'h77;
      end
      if (dbg_at >= 0 && i == dbg_at + 1) dbg_valid_i = 1'b0;
      if ((i % DIV) == DIV - 1 || i == n - 1) begin
        n_tests++;
        if (bad) begin
          n_fail++;
          $display("FAIL frame %02h bit %0d: txd/busy actual %b/%b required %b/1",
                   b, k, a_txd, a_busy, fr[k]);
        end
        bad = 1'b0;
      end
      wait_edge();
    end
    n_tests++;
    if (acc_bad) begin
      n_fail++;
      $display("FAIL accept during frame %02h: actual high required low", b);
    end
  endtask

  initial begin
    logic exp_d;
    logic idle_bad;

    vecs[0] = '{rst: 1'b0, dv: 1'b0, sv: 1'b0, exp_da: 1'b0, exp_sa: 1'b0};
    vecs[1] = '{rst: 1'b0, dv: 1'b1, sv: 1'b0, exp_da: 1'b1, exp_sa: 1'b0};
    vecs[2] = '{rst: 1'b0, dv: 1'b0, sv: 1'b1, exp_da: 1'b0, exp_sa: 1'b1};
    vecs[3] = '{rst: 1'b0, dv: 1'b1, sv: 1'b1, exp_da: 1'b1, exp_sa: 1'b0};
    vecs[4] = '{rst: 1'b1, dv: 1'b1, sv: 1'b0, exp_da: 1'b0, exp_sa: 1'b0};
    vecs[5] = '{rst: 1'b1, dv: 1'b0, sv: 1'b1, exp_da: 1'b0, exp_sa: 1'b0};
    vecs[6] = '{rst: 1'b1, dv: 1'b1, sv: 1'b1, exp_da: 1'b0, exp_sa: 1'b0};

    repeat (3) wait_edge();
    check1("reset txd", {31'd0, txd_o}, 32'd1);
    check1("reset busy", {31'd0, busy_o}, 32'd0);
    check1("reset owner", {31'd0, owner_o}, 32'd0);
    rst_i = 1'b0;
    wait_edge();

    // Combinational grant table, each entry followed by a reset so no frame starts.
    for (int v = 0; v < 7; v++) begin
      rst_i = vecs[v].rst;
      dbg_valid_i = vecs[v].dv;
      soc_valid_i = vecs[v].sv;
      #1;
      check_accept($sformatf("vec %0d accept", v), vecs[v].exp_da, vecs[v].exp_sa);
      check1($sformatf("vec %0d idle txd/busy", v), {30'd0, txd_o, busy_o}, 32'd2);
      rst_i = 1'b1;
      wait_edge();
      rst_i = 1'b0;
      dbg_valid_i = 1'b0;
      soc_valid_i = 1'b0;
      wait_edge();
    end

    // Single debug byte 0x55.
    dbg_valid_i = 1'b1;
    dbg_data_i = 8'h55;
    #1;
    check_accept("single accept", 1'b1, 1'b0);
    wait_edge();
    dbg_valid_i = 1'b0;
    check_frame(8'h55, 1'b1, FRAME, -1, -1);
    check1("after single txd/busy", {30'd0, txd_o, busy_o}, 32'd2);
    check1("after single owner", {31'd0, owner_o}, 32'd1);

    // Both sources held continuously: arbitration order over four frames.
    rst_i = 1'b1;
    wait_edge();
    rst_i = 1'b0;
    dbg_valid_i = 1'b1;
    dbg_data_i = 8'hA1;
    soc_valid_i = 1'b1;
    soc_data_i = 8'hB2;
    #1;
    for (int f = 0; f < 4; f++) begin
`ifdef UART_TX_ARB_RR_EN
      exp_d = (f % 2 == 0);
`else
      exp_d = 1'b1;
`endif
      check_accept($sformatf("tie accept %0d", f), exp_d, ~exp_d);
      wait_edge();
      check_frame(exp_d ? 8'hA1 : 8'hB2, exp_d, FRAME, -1, -1);
    end
    dbg_valid_i = 1'b0;
    soc_valid_i = 1'b0;
    wait_edge();

    // SoC request raised mid-frame, plus a dropped one-cycle debug pulse.
    dbg_valid_i = 1'b1;
    dbg_data_i = 8'h55;
    #1;
    check_accept("midreq dbg accept", 1'b1, 1'b0);
    wait_edge();
    dbg_valid_i = 1'b0;
    check_frame(8'h55, 1'b1, FRAME, 200, 300);
    check_accept("midreq soc accept", 1'b0, 1'b1);
    wait_edge();
    soc_valid_i = 1'b0;
    soc_data_i = 8'hFF;
    check_frame(8'hB2, 1'b0, FRAME, -1, -1);

    // Reset during data bit 3 aborts the frame; a fresh frame follows.
    dbg_valid_i = 1'b1;
    dbg_data_i = 8'hF0;
    #1;
    check_accept("abort accept", 1'b1, 1'b0);
    wait_edge();
    dbg_valid_i = 1'b0;
    check_frame(8'hF0, 1'b1, 220, -1, -1);
    rst_i = 1'b1;
    dbg_valid_i = 1'b1;
    #1;
    check_accept("accept in reset", 1'b0, 1'b0);
    wait_edge();
    check1("abort txd/busy", {30'd0, txd_o, busy_o}, 32'd2);
    check1("abort owner", {31'd0, owner_o}, 32'd0);
    rst_i = 1'b0;
    dbg_valid_i = 1'b0;
    idle_bad = 1'b0;
    for (int i = 0; i < 2 * DIV; i++) begin
      if (txd_o !== 1'b1 || busy_o !== 1'b0) idle_bad = 1'b1;
      wait_edge();
    end
    check1("no resume after abort", {31'd0, idle_bad}, 32'd0);
    soc_valid_i = 1'b1;
    soc_data_i = 8'h3C;
    #1;
    check_accept("fresh accept", 1'b0, 1'b1);
    wait_edge();
    soc_valid_i = 1'b0;
    check_frame(8'h3C, 1'b0, FRAME, -1, -1);
    check1("after fresh txd/busy", {30'd0, txd_o, busy_o}, 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
